cic_comb_decim: RTL and testbench

CIC_COMB_DECIM -- requirements
Module: cic_comb_decim

---
 rtl/cic_pkg.sv | 11 +
 rtl/cic_comb_stage.sv | 40 ++++
 rtl/cic_comb_decim.sv | 98 +++++++++
 tb/tb_cic_comb_decim.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared CIC constants and sample type, common to the integrator cascade and the comb decimator.
package cic_pkg;

    localparam int unsigned CIC_IN_W  = 37;
    localparam int unsigned CIC_OUT_W = 16;
    localparam int unsigned CIC_DECIM = 512;
    localparam int unsigned CIC_N_STG = 3;

    typedef logic signed [CIC_IN_W-1:0] cic_sample_t;

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator (M=1): y = x - x(previous strobed sample), wrap-around arithmetic.
module cic_comb_stage
    import cic_pkg::*;
#(
    parameter int unsigned W = CIC_IN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_vld,
    input  logic signed [W-1:0] i_x,
    output logic signed [W-1:0] o_y,
    output logic                o_vld,
    output logic signed [W-1:0] o_diff_c
);

    logic signed [W-1:0] r_prev;
    logic signed [W-1:0] r_y;
    logic                r_vld;

    // Next output value, exposed so downstream logic can register a scaled copy on the same edge.
    assign o_diff_c = i_x - r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
            r_y    <= '0;
            r_vld  <= 1'b0;
        end else begin
            r_vld <= i_vld;
            if (i_vld) begin
                r_prev <= i_x;
                r_y    <= o_diff_c;
            end
        end
    end

    assign o_y   = r_y;
    assign o_vld = r_vld;

endmodule

// File: rtl/cic_comb_decim.sv
// CIC decimator back end: rate-R capture of the integrator output followed by N_STG comb stages.
// Define CIC_COMB_ROUND_EN for round-half-up scaling with positive saturation; default truncates.
module cic_comb_decim
    import cic_pkg::*;
#(
    parameter int unsigned IN_W  = CIC_IN_W,
    parameter int unsigned OUT_W = CIC_OUT_W,
    parameter int unsigned DECIM = CIC_DECIM,
    parameter int unsigned N_STG = CIC_N_STG
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    InEn,
    input  logic signed [IN_W-1:0]  Intin,
    output logic signed [IN_W-1:0]  Dout,
    output logic signed [OUT_W-1:0] Yout,
    output logic                    Yvalid
);

    localparam int unsigned CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int unsigned FRAC_W = IN_W - OUT_W;

    logic [CNT_W-1:0]        r_cnt;
    logic signed [IN_W-1:0]  r_cap;
    logic                    r_s0;
    logic signed [OUT_W-1:0] r_yout;
    logic                    w_wrap;
    logic signed [OUT_W-1:0] w_y;

    logic signed [IN_W-1:0]  w_x    [0:N_STG];
    logic                    w_v    [0:N_STG];
    logic signed [IN_W-1:0]  w_diff [0:N_STG-1];

    assign w_wrap = InEn && (r_cnt == CNT_W'(DECIM - 1));

    // Decimation counter and sample capture; only InEn-qualified cycles advance the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_cap <= '0;
            r_s0  <= 1'b0;
        end else begin
            r_s0 <= w_wrap;
            if (w_wrap) begin
                r_cnt <= '0;
                r_cap <= Intin;
            end else if (InEn) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_x[0] = r_cap;
    assign w_v[0] = r_s0;

    for (genvar k = 0; k < N_STG; k++) begin : g_stg
        cic_comb_stage #(
            .W (IN_W)
        ) u_stg (
            .clk      (clk),
            .rst      (rst),
            .i_vld    (w_v[k]),
            .i_x      (w_x[k]),
            .o_y      (w_x[k+1]),
            .o_vld    (w_v[k+1]),
            .o_diff_c (w_diff[k])
        );
    end

`ifdef CIC_COMB_ROUND_EN
    localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (FRAC_W - 1);

    logic signed [IN_W:0] w_sum;
    logic [OUT_W:0]       w_top;

    // One guard bit above the sum; only a positive input can overflow when adding half an LSB.
    assign w_sum = {w_diff[N_STG-1][IN_W-1], w_diff[N_STG-1]} + HALF;
    assign w_top = w_sum[IN_W -: OUT_W + 1];
    assign w_y   = (w_top[OUT_W] != w_top[OUT_W-1]) ? {1'b0, {(OUT_W - 1){1'b1}}}
                                                    : w_top[OUT_W-1:0];
`else
    assign w_y = w_diff[N_STG-1][IN_W-1 -: OUT_W];
`endif

    // Scaled output registered on the same edge as the last comb stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_yout <= '0;
        end else if (w_v[N_STG-1]) begin
            r_yout <= w_y;
        end
    end

    assign Dout   = w_x[N_STG];
    assign Yvalid = w_v[N_STG];
    assign Yout   = r_yout;

endmodule

// File: tb/tb_cic_comb_decim.sv
// Directed bench for cic_comb_decim: integrator-fed and directly driven Intin, InEn gating, reset and wrap.
`timescale 1ns/1ps
module tb_cic_comb_decim;
    import cic_pkg::*;

    localparam int unsigned IN_W  = CIC_IN_W;
    localparam int unsigned OUT_W = CIC_OUT_W;
    localparam int unsigned DECIM = CIC_DECIM;
    localparam int          LIMIT = 3000;

    localparam longint K     = 3 * (64'sd1 <<< 20);
    localparam longint P27   = 64'sd1 <<< 27;
    localparam longint RB    = (64'sd1 <<< 36) - 10 * 512;
    localparam longint RC0   = (64'sd1 <<< 36) - 2560;
    localparam longint RC2   = (64'sd1 <<< 36) - 5120;
`ifdef CIC_COMB_ROUND_EN
    localparam longint YK    = 2;
    localparam longint YR1   = 0;
`else
    localparam longint YK    = 1;
    localparam longint YR1   = -1;
`endif

    typedef struct {
        bit     rst_before;
        int     mode;        // 0 const Intin, 1 integrator, 2 ramp step 5, 3 integrator with InEn toggling
        longint val;
        bit     chk;
        longint exp_d;
        longint exp_y;
        int     exp_gap;
        string  name;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    InEn;
    logic signed [IN_W-1:0]  Intin;
    logic signed [IN_W-1:0]  Dout;
    logic signed [OUT_W-1:0] Yout;
    logic                    Yvalid;

    vec_t        tv[$];
    int          checks;
    int          errors;
    int          mode;
    int          gap;
    logic        phase;
    cic_sample_t val, acc1, acc2, acc3, ramp;

    always #5 clk = ~clk;

    cic_comb_decim #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DECIM (DECIM)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .InEn   (InEn),
        .Intin  (Intin),
        .Dout   (Dout),
        .Yout   (Yout),
        .Yvalid (Yvalid)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input int m, input longint v, input bit c,
                       input longint d, input longint y, input int g, input string n);
        tv.push_back('{r, m, v, c, d, y, g, n});
    endtask

    // Drive one clock of stimulus from the source model, sample 1ns after the edge.
    task automatic tick();
        logic en;
        @(negedge clk);
        rst   = 1'b0;
        en    = (mode == 3) ? ~phase : 1'b1;
        phase = ~phase;
        if (en) begin
            case (mode)
                0: Intin = val;
                2: begin
                    ramp  = ramp + IN_W'(5);
                    Intin = ramp;
                end
                default: begin
                    acc1  = acc1 + val;
                    acc2  = acc2 + acc1;
                    acc3  = acc3 + acc2;
                    Intin = acc3;
                end
            endcase
        end
        InEn = en;
        @(posedge clk);
        #1;
        gap++;
    endtask

    task automatic do_reset(input logic en, input int m, input longint v);
        @(negedge clk);
        rst  = 1'b1;
        InEn = en;
        @(posedge clk);
        #1;
        check("rst_dout",   longint'(Dout),   0);
        check("rst_yout",   longint'(Yout),   0);
        check("rst_yvalid", longint'(Yvalid), 0);
        mode  = m;
        val   = IN_W'(v);
        ramp  = IN_W'(v);
        acc1  = '0;
        acc2  = '0;
        acc3  = '0;
        phase = 1'b0;
        gap   = 0;
    endtask

    task automatic wait_strobe(input string name, input int exp_gap);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (Yvalid !== 1'b1 && n < LIMIT);
        checks++;
        if (Yvalid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: no Yvalid in %0d cycles, expected after %0d", name, n, exp_gap);
        end else if (gap != exp_gap) begin
            errors++;
            $display("FAIL %s_gap: Yvalid after %0d cycles, expected %0d", name, gap, exp_gap);
        end
        gap = 0;
    endtask

    initial begin
        rst    = 1'b1;
        InEn   = 1'b0;
        Intin  = '0;
        checks = 0;
        errors = 0;
        mode   = 0;
        gap    = 0;
        phase  = 1'b0;
        val    = '0;
        acc1   = '0;
        acc2   = '0;
        acc3   = '0;
        ramp   = '0;

        add(1, 0, K,    1,  K,     YK,     515, "const_k0");
        add(0, 0, K,    1, -2 * K, -3,     512, "const_k1");
        add(0, 0, K,    1,  K,     YK,     512, "const_k2");
        add(0, 0, K,    1,  0,     0,      512, "const_k3");
        add(1, 1, 1,    0,  0,     0,      515, "int1_s0");
        add(0, 1, 1,    0,  0,     0,      512, "int1_s1");
        add(0, 1, 1,    1,  P27,   64,     512, "int1_s2");
        add(0, 1, 1,    1,  P27,   64,     512, "int1_s3");
        add(1, 1, 511,  0,  0,     0,      515, "int511_s0");
        add(0, 1, 511,  0,  0,     0,      512, "int511_s1");
        add(0, 1, 511,  1,  511 * P27, 32704, 512, "int511_s2");
        add(1, 1, -512, 0,  0,     0,      515, "intm512_s0");
        add(0, 1, -512, 0,  0,     0,      512, "intm512_s1");
        add(0, 1, -512, 1, -512 * P27, -32768, 512, "intm512_s2");
        add(1, 3, 1,    0,  0,     0,      1026, "toggle_s0");
        add(0, 3, 1,    0,  0,     0,      1024, "toggle_s1");
        add(0, 3, 1,    1,  P27,   64,     1024, "toggle_s2");
        add(1, 2, 0,    1,  2560,  0,      515, "ramp0_s0");
        add(0, 2, 0,    1, -2560,  YR1,    512, "ramp0_s1");
        add(0, 2, 0,    1,  0,     0,      512, "ramp0_s2");
        add(0, 2, 0,    1,  0,     0,      512, "ramp0_s3");
        add(1, 2, RB,   1,  RC0,   32767,  515, "rampw_s0");
        add(0, 2, RB,   1,  7680,  0,      512, "rampw_s1");
        add(0, 2, RB,   1,  RC2,   32767,  512, "rampw_s2");
        add(0, 2, RB,   1,  0,     0,      512, "rampw_s3");
        add(0, 2, RB,   1,  0,     0,      512, "rampw_s4");

        foreach (tv[i]) begin
            if (tv[i].rst_before) do_reset(1'b0, tv[i].mode, tv[i].val);
            wait_strobe(tv[i].name, tv[i].exp_gap);
            if (tv[i].chk) begin
                check({tv[i].name, "_dout"}, longint'(Dout), tv[i].exp_d);
                check({tv[i].name, "_yout"}, longint'(Yout), tv[i].exp_y);
            end
            tick();
            check({tv[i].name, "_pulse"}, longint'(Yvalid), 0);
            if (tv[i].chk) check({tv[i].name, "_hold"}, longint'(Dout), tv[i].exp_d);
        end

        // Reset at E1 of an in-flight sample, with InEn high in the same cycle.
        do_reset(1'b0, 0, K);
        while (gap < 512) tick();
        do_reset(1'b1, 0, K);
        tick();
        check("midrst_e2", longint'(Yvalid), 0);
        tick();
        check("midrst_e3", longint'(Yvalid), 0);
        check("midrst_e3_dout", longint'(Dout), 0);
        wait_strobe("midrst_next", 515);
        check("midrst_dout", longint'(Dout), K);
        check("midrst_yout", longint'(Yout), YK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
